pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W). Merges the single-cycle
//  hazard requests (load-use stall, taken branch/jump) with multi-cycle events: data-memory
//  miss in M and multi-cycle mul/div in E. Drives every pipeline register's stall and flush.
//  Watchdog on wait states. Sits beside the forwarding/hazard logic in the top-level.
// PARAMETERS
//  TIMEOUT      64  max cycles in any wait state before ERROR (>=2)
//  CNT_W        32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous, active-high reset
//  LoadUseE      in   1      load-use hazard request (1-cycle bubble)
//  RedirectE     in   1      taken branch/jump resolved in E (PCSrc)
//  DMissM        in   1      data access in M cannot complete this cycle
//  DReadyM       in   1      outstanding data access completes this cycle
//  MduStartE     in   1      multi-cycle mul/div occupies E
//  MduDoneE      in   1      mul/div result valid this cycle
//  StallF/D/E/M  out  1 each hold the stage register
//  FlushD/E/M/W  out  1 each load a bubble (NOP, RegWrite=0, MemWrite=0)
//  Error         out  1      watchdog expired; sticky until rst
//  StallCycles   out  CNT_W  cycles with any Stall* high
//  FlushCount    out  CNT_W  taken redirects acted on
// BEHAVIOUR
//  - FSM states: RUN, MEM_WAIT, MDU_WAIT, ERROR. rst -> RUN, timer=0, Error=0, counters=0.
//    Outputs are combinational from state+inputs. While rst=1: Stall*=0, Flush*=1.
//  - RUN priority: DMissM > MduStartE > RedirectE > LoadUseE; one action per cycle.
//    DMissM: StallF/D/E/M=1, FlushW=1; next state MEM_WAIT.
//    MduStartE (no miss): StallF/D/E=1, FlushM=1; next state MDU_WAIT.
//    RedirectE: FlushD=FlushE=1, no stall; FlushCount+1. Overrides LoadUseE (wrong path).
//    LoadUseE: StallF=StallD=1, FlushE=1. Exactly one bubble; stays RUN.
//  - MEM_WAIT: StallF/D/E/M=1, FlushW=1 each cycle until DReadyM=1. In the DReadyM cycle all
//    Stall*=0, FlushW=0 (M retires); next RUN. Zero wait: DMissM=DReadyM=1 in RUN is not
//    a miss (no stall).
//  - MDU_WAIT: StallF/D/E=1, FlushM=1 until MduDoneE=1. In the done cycle stalls drop, E
//    advances; next RUN. MduStartE=MduDoneE=1 in RUN: no stall.
//  - In wait states, RedirectE/LoadUseE are ignored (no flush); the held E instruction
//    re-presents them after release, so no pending register is needed.
//  - DMissM during MDU_WAIT: ignored until RUN (M holds a bubble, cannot miss).
//  - Timer: cleared on entry to a wait state, +1 per wait cycle. Timer==TIMEOUT-1 with no
//    ready/done -> ERROR. ERROR: all Stall*=1, Flush*=0, Error=1; left only by rst.
//  - Reset mid-wait: next cycle RUN; the outstanding miss/mdu is discarded.
// CONFIGURATION
//  PERF_CNT_EN defined: StallCycles +1 every cycle any Stall*=1. FlushCount +1 per acted-on
//  redirect. Both wrap at 2^CNT_W. Not defined: counters are not built, both ports tied 0.
// STRUCTURE
//  pipeline_ctrl_pkg: typedef enum logic [1:0] ctrl_state_t {RUN, MEM_WAIT, MDU_WAIT,
//  ERROR}; stage-index localparams; TIMEOUT default constant.
//  Sub-module wait_timer: clear/enable up-counter, $clog2(TIMEOUT) bits, expired flag.
// TESTING
//  1 LoadUseE=1 one cycle in RUN -> StallF=StallD=FlushE=1 for exactly that cycle, RUN held.
//  2 RedirectE=LoadUseE=1 -> FlushD=FlushE=1, StallF=0; FlushCount 0->1 (PERF_CNT_EN).
//  3 DMissM at t0, DReadyM at t3 -> StallF..M=1, FlushW=1 on t0..t2; all 0 at t3; RUN at t4.
//  4 MduStartE at t0, MduDoneE at t5 -> StallF/D/E=1, FlushM=1 t0..t4; released t5.
//  5 DMissM with no DReadyM, TIMEOUT=8 -> Error=1 after 8 wait cycles; sticky until rst.
//  6 rst at t2 of MEM_WAIT -> t3 RUN, Stall*=0, Error=0, counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT, ERROR} ctrl_state_t;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;

  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_ctrl_wait_timer.sv
// Wait-state watchdog: clearable up-counter that saturates at TIMEOUT-1 and flags expiry.
module pipeline_ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with a wait-state watchdog.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LoadUseE,
  input  logic             RedirectE,
  input  logic             DMissM,
  input  logic             DReadyM,
  input  logic             MduStartE,
  input  logic             MduDoneE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             Error,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  ctrl_state_t state_q, state_d;

  logic [STG_M:STG_F] stall;
  logic [STG_W:STG_D] flush;
  logic               redirect_taken;
  logic               timer_en;
  logic               expired;

  always_comb begin
    state_d        = state_q;
    stall          = '0;
    flush          = '0;
    redirect_taken = 1'b0;
    timer_en       = 1'b0;
    if (rst) begin
      flush   = '1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          // A miss or mdu op that completes in the same cycle needs no wait.
          if (DMissM && !DReadyM) begin
            stall        = '1;
            flush[STG_W] = 1'b1;
            state_d      = MEM_WAIT;
          end else if (MduStartE && !MduDoneE) begin
            stall[STG_E:STG_F] = '1;
            flush[STG_M]       = 1'b1;
            state_d            = MDU_WAIT;
          end else if (RedirectE) begin
            flush[STG_E:STG_D] = '1;
            redirect_taken     = 1'b1;
          end else if (LoadUseE) begin
            stall[STG_D:STG_F] = '1;
            flush[STG_E]       = 1'b1;
          end
        end
        MEM_WAIT: begin
          timer_en = 1'b1;
          if (DReadyM) begin
            state_d = RUN;
          end else begin
            stall        = '1;
            flush[STG_W] = 1'b1;
            if (expired) state_d = ERROR;
          end
        end
        MDU_WAIT: begin
          timer_en = 1'b1;
          if (MduDoneE) begin
            state_d = RUN;
          end else begin
            stall[STG_E:STG_F] = '1;
            flush[STG_M]       = 1'b1;
            if (expired) state_d = ERROR;
          end
        end
        ERROR: begin
          stall = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Timer is held clear in RUN so it starts from zero on every wait entry.
  pipeline_ctrl_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == RUN),
    .enable (timer_en),
    .expired(expired)
  );

  assign StallF = stall[STG_F];
  assign StallD = stall[STG_D];
  assign StallE = stall[STG_E];
  assign StallM = stall[STG_M];
  assign FlushD = flush[STG_D];
  assign FlushE = flush[STG_E];
  assign FlushM = flush[STG_M];
  assign FlushW = flush[STG_W];
  assign Error  = (state_q == ERROR);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|stall)         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_taken) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect_taken;
  assign StallCycles     = '0;
  assign FlushCount      = '0;
`endif

endmodule
